// File: rtl/instr_prefetch_pkg.sv
// Shared fetch/decode definitions: fetch FSM state codes, the NOP word and
// the default word-address width (sized for the const27 jump field).
package instr_prefetch_pkg;

    localparam int unsigned ADDR_W_DEF = 27;
    localparam int unsigned INSTR_W    = 32;

    // Fetch FSM state codes (2-bit, shared with later pipeline stages)
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries.
// Ports: clk, reset (sync, active-high), push/wdata (enqueue), pop (dequeue
// head), clear (empty the FIFO; beats push and pop), count (occupancy),
// head (oldest entry, meaningful only when count != 0).
module instr_prefetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 59
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Entry storage; no reset needed since head is qualified by count
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally on a power-of-two depth
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: issues word reads from fetch_pc, buffers the
// returned words, and presents the FIFO head to decode.
// Ports: clk, reset (sync, active-high); bus_addr/bus_start/bus_done/bus_q
// (single-outstanding memory read bus); stall (decode holds head); flush /
// flush_pc (drop everything, redirect fetch); instr/instr_pc/instr_valid
// (head entry to decode, zeroed when empty).
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_start,
    input  logic              bus_done,
    input  logic [31:0]       bus_q,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic                issue;
    logic                push;
    logic                pop;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [CNT_W-1:0]    count;
    logic [ENTRY_W-1:0]  head;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; only IDLE may issue, so at most one request is ever in flight
    // and count < depth alone guarantees room for the returning word.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!flush && (count < CNT_W'(FIFO_DEPTH))) begin
                    state_next = ST_WAIT;
                    issue      = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus_done) begin
                    state_next = ST_IDLE;
                    push       = !flush;
                end else if (flush) begin
                    state_next = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (bus_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus request and fetch address; a redirect overrides the increment
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_start <= 1'b0;
            bus_addr  <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else begin
            bus_start <= issue;
            if (issue) begin
                bus_addr <= fetch_pc;
            end
            if (flush) begin
                fetch_pc <= flush_pc;
            end else if (push) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
        end
    end

    assign pop = instr_valid && !stall && !flush;

    instr_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata ({bus_addr, bus_q}),
        .count (count),
        .head  (head)
    );

    // Decode-facing view of the head, forced to zero when empty
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head[INSTR_W-1:0] : NOP_INSTR;
    assign instr_pc    = instr_valid ? head[ENTRY_W-1:INSTR_W] : '0;

endmodule

// File: tb/tb_instr_prefetch.sv
module tb_instr_prefetch;

    localparam int unsigned AW    = 27;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] bus_addr;
    logic          bus_start;
    logic          bus_done = 1'b0;
    logic [31:0]   bus_q = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] flush_pc = '0;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;

    always #5 clk = ~clk;

    instr_prefetch #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .RESET_PC('0)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_addr    (bus_addr),
        .bus_start   (bus_start),
        .bus_done    (bus_done),
        .bus_q       (bus_q),
        .stall       (stall),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [31:0]   w;
    } ent_t;

    ent_t          mq[$];
    bit            m_busy  = 0;  // request in flight whose word will be kept
    bit            m_drop  = 0;  // request in flight whose word is discarded
    bit            m_start = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [AW-1:0] m_pc    = '0;
    int            m_pre;
    bit            m_pop;
    bit            m_nstart;
    bit            cmp_en = 0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_busy = 0; m_drop = 0; m_start = 0;
            m_pc = '0; m_addr = '0;
        end else begin
            m_pre    = mq.size();
            m_pop    = (m_pre > 0) && !stall && !flush;
            m_nstart = 0;
            if (m_pop) void'(mq.pop_front());
            if (m_busy) begin
                if (bus_done) begin
                    m_busy = 0;
                    if (!flush) begin
                        mq.push_back('{m_addr, bus_q});
                        m_pc = m_pc + 1'b1;
                    end
                end else if (flush) begin
                    m_busy = 0;
                    m_drop = 1;
                end
            end else if (m_drop) begin
                if (bus_done) m_drop = 0;
            end else if (!flush && m_pre < DEPTH) begin
                m_nstart = 1;
                m_addr   = m_pc;
                m_busy   = 1;
            end
            if (flush) begin
                mq.delete();
                m_pc = flush_pc;
            end
            m_start = m_nstart;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("bus_start", bus_start, m_start);
            chk("bus_addr", bus_addr, m_addr);
            chk("instr_valid", instr_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("instr", instr, mq[0].w);
                chk("instr_pc", instr_pc, mq[0].pc);
            end else begin
                chk("instr_zero", instr, 0);
                chk("instr_pc_zero", instr_pc, 0);
            end
        end
    end

    // ---------------- bus responder / stimulus ----------------
    int lat_fixed = 2;   // <0 selects random latency 0..3
    bit r_active  = 0;
    int r_cnt     = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus_start) begin
            r_active = 1;
            r_cnt    = (lat_fixed < 0) ? int'($urandom_range(3, 0)) : lat_fixed;
        end
        bus_done = 1'b0;
        bus_q    = $urandom;
        if (r_active) begin
            if (r_cnt == 0) begin
                bus_done = 1'b1;
                r_active = 0;
            end else begin
                r_cnt--;
            end
        end
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        cyc();
        while (!bus_start && n < 50) begin
            cyc();
            n++;
        end
        chk(nm, bus_start, 1);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!instr_valid && n < 50) begin
            cyc();
            n++;
        end
        chk(nm, instr_valid, 1);
    endtask

    logic [31:0] first_word;
    int          starts;

    initial begin
        // Test 1: reset, latency 2, no stall
        reset = 1'b1;
        cyc();
        cmp_en = 1;
        chk("rst_valid", instr_valid, 0);
        chk("rst_start", bus_start, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_instr", instr, 0);
        cyc();
        reset = 1'b0;
        cyc();
        chk("t1_start0", bus_start, 1);
        chk("t1_addr0", bus_addr, 0);
        cyc();
        chk("t1_no_b2b", bus_start, 0);
        cyc();
        chk("t1_done", bus_done, 1);
        chk("t1_notyet", instr_valid, 0);
        first_word = bus_q;
        cyc();
        chk("t1_valid", instr_valid, 1);
        chk("t1_pc0", instr_pc, 0);
        chk("t1_word0", instr, first_word);
        cyc();
        chk("t1_start1", bus_start, 1);
        chk("t1_addr1", bus_addr, 1);
        repeat (12) cyc();

        // Test 2: stall fills the FIFO and stops requests
        lat_fixed = 1;
        stall = 1'b1;
        repeat (20) cyc();
        starts = 0;
        repeat (10) begin
            cyc();
            if (bus_start) starts++;
        end
        chk("t2_full_nostart", starts, 0);
        chk("t2_valid", instr_valid, 1);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_drain_valid", instr_valid, 1);
            cyc();
        end
        wait_start("t2_resume");

        // Test 3: flush while waiting, stale word arrives 3 cycles later
        lat_fixed = 3;
        wait_start("t3_start");
        flush = 1'b1;
        flush_pc = 27'h100;
        cyc();
        flush = 1'b0;
        chk("t3_flushed", instr_valid, 0);
        wait_start("t3_restart");
        chk("t3_addr", bus_addr, 27'h100);
        wait_valid("t3_wait_valid");
        chk("t3_pc", instr_pc, 27'h100);

        // Test 4: flush in the same cycle as bus_done
        lat_fixed = 2;
        wait_start("t4_start");
        cyc();
        cyc();
        chk("t4_done", bus_done, 1);
        flush = 1'b1;
        flush_pc = 27'h200;
        cyc();
        flush = 1'b0;
        chk("t4_empty", instr_valid, 0);
        wait_start("t4_restart");
        chk("t4_addr", bus_addr, 27'h200);

        // Test 5: fetch address wraps
        lat_fixed = 1;
        flush = 1'b1;
        flush_pc = 27'h7FF_FFFF;
        cyc();
        flush = 1'b0;
        wait_valid("t5_wait_top");
        chk("t5_pc_top", instr_pc, 27'h7FF_FFFF);
        cyc();
        wait_valid("t5_wait_wrap");
        chk("t5_pc_wrap", instr_pc, 0);
        repeat (6) cyc();

        // Test 6: reset during WAIT, late bus_done is ignored
        wait_start("t6_start");
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_late_done", bus_done, 1);
        chk("t6_rst_start", bus_start, 0);
        chk("t6_rst_valid", instr_valid, 0);
        chk("t6_rst_addr", bus_addr, 0);
        cyc();
        chk("t6_restart", bus_start, 1);
        chk("t6_restart_addr", bus_addr, 0);
        repeat (4) cyc();

        // Random phase
        lat_fixed = -1;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            stall = ($urandom_range(2, 0) == 0);
            flush = ($urandom_range(39, 0) == 0);
            flush_pc = ($urandom_range(1, 0) == 0) ? AW'($urandom)
                                                   : (27'h7FF_FFFE + AW'($urandom_range(1, 0)));
            reset = ($urandom_range(299, 0) == 0);
        end
        stall = 1'b0;
        flush = 1'b0;
        reset = 1'b0;
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
